// File: rtl/flash_page_reader.sv
// ---------------------------------------------------------------------------------------------
// flash_page_reader
//
// Sequences a NAND page read: 00h command, five address cycles, 30h command, a fixed tWB
// wait, a bounded wait for R/B# ready, then a word-by-word read loop. Each command, address
// and read step is a one-cycle request strobe to an external timing controller followed by
// a wait for that controller's completion pulse.
//
// Parameters
//   TWB_CYCLES      cycles spent in TWB after the 30h command (minimum effective value 1)
//   TIMEOUT_CYCLES  WAIT_RDY cycles without ready before giving up (minimum effective value 1)
//
// Ports
//   i_master_clk, i_reset_n        clock, asynchronous active-low reset
//   i_req, i_col_addr, i_row_addr, i_word_count
//                                  start strobe and transfer descriptor (latched in IDLE)
//   o_busy                         high whenever not IDLE
//   o_data, o_data_valid           read words, one cycle after i_rd_data_valid
//   o_done, o_error                completion pulse; o_error marks a ready timeout
//   o_cmd_request/o_cmd_data/i_cmd_done   command handshake
//   o_ad_request/o_ad_data/i_ad_done      address handshake
//   o_rd_request/i_rd_data/i_rd_data_valid read handshake
//   i_chip_ready                   raw R/B# pin, synchronized internally
// ---------------------------------------------------------------------------------------------
module flash_page_reader #(
    parameter int unsigned TWB_CYCLES     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        i_master_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic [11:0] i_col_addr,
    input  logic [23:0] i_row_addr,
    input  logic [11:0] i_word_count,
    output logic        o_busy,
    output logic [15:0] o_data,
    output logic        o_data_valid,
    output logic        o_done,
    output logic        o_error,
    output logic        o_cmd_request,
    output logic [7:0]  o_cmd_data,
    input  logic        i_cmd_done,
    output logic        o_ad_request,
    output logic [7:0]  o_ad_data,
    input  logic        i_ad_done,
    output logic        o_rd_request,
    input  logic [15:0] i_rd_data,
    input  logic        i_rd_data_valid,
    input  logic        i_chip_ready
);

    // One shared wait counter covers both TWB and WAIT_RDY; it only needs to reach N-1.
    localparam int unsigned MaxWait = (TWB_CYCLES > TIMEOUT_CYCLES) ? TWB_CYCLES
                                                                    : TIMEOUT_CYCLES;
    localparam int unsigned CntW    = (MaxWait < 3) ? 1 : $clog2(MaxWait);

    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] TwbLast = (TWB_CYCLES == 0) ? '0 : CntW'(TWB_CYCLES - 1);
    localparam logic [CntW-1:0] TmoLast = (TIMEOUT_CYCLES == 0) ? '0
                                                                : CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CmdRead0 = 8'h00;
    localparam logic [7:0] CmdRead1 = 8'h30;

    typedef enum logic [2:0] {
        StIdle,
        StCmd00,
        StAddr,
        StCmd30,
        StTwb,
        StWaitRdy,
        StRead,
        StDone
    } state_e;

    state_e            state_q, state_d;
    // Set once the current step's request strobe has gone out; completion pulses are
    // only honoured while it is set, which also keeps strobes one cycle wide.
    logic              sent_q, sent_d;
    logic [2:0]        addr_idx_q, addr_idx_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [11:0]       words_q, words_d;
    logic              timeout_q, timeout_d;
    logic [11:0]       col_q;
    logic [23:0]       row_q;
    logic              rdy_meta_q, rdy_sync_q;
    logic [15:0]       data_q;
    logic              data_valid_q, data_valid_d;
    logic              start;
    logic [7:0]        addr_byte;

    assign start = (state_q == StIdle) && i_req;

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            sent_q     <= 1'b0;
            addr_idx_q <= '0;
            wait_cnt_q <= '0;
            words_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sent_q     <= sent_d;
            addr_idx_q <= addr_idx_d;
            wait_cnt_q <= wait_cnt_d;
            words_q    <= words_d;
            timeout_q  <= timeout_d;
        end
    end

    // Transfer descriptor, captured only on the accepted start strobe.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (start) begin
            col_q <= i_col_addr;
            row_q <= i_row_addr;
        end
    end

    // Two-flop synchronizer for the asynchronous R/B# pin.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
        end else begin
            rdy_meta_q <= i_chip_ready;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    // Read data path: one register stage gives the fixed one-cycle latency.
    assign data_valid_d = (state_q == StRead) && sent_q && i_rd_data_valid;

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= data_valid_d;
            if (data_valid_d) begin
                data_q <= i_rd_data;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sent_d     = sent_q;
        addr_idx_d = addr_idx_q;
        wait_cnt_d = wait_cnt_q;
        words_d    = words_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    state_d    = StCmd00;
                    sent_d     = 1'b0;
                    addr_idx_d = '0;
                    wait_cnt_d = '0;
                    words_d    = i_word_count;
                    timeout_d  = 1'b0;
                end
            end

            StCmd00: begin
                if (!sent_q) begin
                    sent_d = 1'b1;
                end else if (i_cmd_done) begin
                    state_d    = StAddr;
                    sent_d     = 1'b0;
                    addr_idx_d = '0;
                end
            end

            StAddr: begin
                if (!sent_q) begin
                    sent_d = 1'b1;
                end else if (i_ad_done) begin
                    sent_d = 1'b0;
                    if (addr_idx_q == 3'd4) begin
                        state_d = StCmd30;
                    end else begin
                        addr_idx_d = addr_idx_q + 3'd1;
                    end
                end
            end

            StCmd30: begin
                if (!sent_q) begin
                    sent_d = 1'b1;
                end else if (i_cmd_done) begin
                    state_d    = StTwb;
                    sent_d     = 1'b0;
                    wait_cnt_d = '0;
                end
            end

            StTwb: begin
                // Counter stops at its terminal value rather than wrapping.
                if (wait_cnt_q >= TwbLast) begin
                    state_d    = StWaitRdy;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntOne;
                end
            end

            StWaitRdy: begin
                if (rdy_sync_q) begin
                    state_d = (words_q == 12'd0) ? StDone : StRead;
                    sent_d  = 1'b0;
                end else if (wait_cnt_q >= TmoLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntOne;
                end
            end

            StRead: begin
                if (!sent_q) begin
                    sent_d = 1'b1;
                end else if (i_rd_data_valid) begin
                    sent_d  = 1'b0;
                    words_d = words_q - 12'd1;
                    if (words_q == 12'd1) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d   = StIdle;
                timeout_d = 1'b0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        addr_byte = 8'h00;
        unique case (addr_idx_q)
            3'd0:    addr_byte = col_q[7:0];
            3'd1:    addr_byte = {4'b0000, col_q[11:8]};
            3'd2:    addr_byte = row_q[7:0];
            3'd3:    addr_byte = row_q[15:8];
            3'd4:    addr_byte = row_q[23:16];
            default: addr_byte = 8'h00;
        endcase
    end

    always_comb begin
        o_cmd_data = 8'h00;
        if (state_q == StCmd00) begin
            o_cmd_data = CmdRead0;
        end else if (state_q == StCmd30) begin
            o_cmd_data = CmdRead1;
        end
    end

    // Address byte is held for the whole ADDR step, so it is stable until i_ad_done.
    assign o_ad_data     = (state_q == StAddr) ? addr_byte : 8'h00;

    assign o_cmd_request = ((state_q == StCmd00) || (state_q == StCmd30)) && !sent_q;
    assign o_ad_request  = (state_q == StAddr) && !sent_q;
    assign o_rd_request  = (state_q == StRead) && !sent_q;

    assign o_busy        = (state_q != StIdle);
    assign o_done        = (state_q == StDone);
    assign o_error       = (state_q == StDone) && timeout_q;
    assign o_data        = data_q;
    assign o_data_valid  = data_valid_q;

endmodule

// File: tb/tb_flash_page_reader.sv
// Directed bench for flash_page_reader with a behavioural timing controller.
module tb_flash_page_reader;

    logic        clk;
    logic        i_reset_n;
    logic        i_req;
    logic [11:0] i_col_addr;
    logic [23:0] i_row_addr;
    logic [11:0] i_word_count;
    logic        o_busy;
    logic [15:0] o_data;
    logic        o_data_valid;
    logic        o_done;
    logic        o_error;
    logic        o_cmd_request;
    logic [7:0]  o_cmd_data;
    logic        i_cmd_done;
    logic        o_ad_request;
    logic [7:0]  o_ad_data;
    logic        i_ad_done;
    logic        o_rd_request;
    logic [15:0] i_rd_data;
    logic        i_rd_data_valid;
    logic        i_chip_ready;

    flash_page_reader #(
        .TWB_CYCLES     (20),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_master_clk    (clk),
        .i_reset_n       (i_reset_n),
        .i_req           (i_req),
        .i_col_addr      (i_col_addr),
        .i_row_addr      (i_row_addr),
        .i_word_count    (i_word_count),
        .o_busy          (o_busy),
        .o_data          (o_data),
        .o_data_valid    (o_data_valid),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_cmd_request   (o_cmd_request),
        .o_cmd_data      (o_cmd_data),
        .i_cmd_done      (i_cmd_done),
        .o_ad_request    (o_ad_request),
        .o_ad_data       (o_ad_data),
        .i_ad_done       (i_ad_done),
        .o_rd_request    (o_rd_request),
        .i_rd_data       (i_rd_data),
        .i_rd_data_valid (i_rd_data_valid),
        .i_chip_ready    (i_chip_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- logs (monitor-owned)
    logic [7:0]  cmd_q[$];
    logic [7:0]  ad_q[$];
    logic [15:0] data_q[$];
    int cyc = 0, done_cnt = 0, err_cnt = 0, err_alone = 0, rd_req_cnt = 0;
    int overlap = 0, stab_err = 0, done_t = 0, cmd30_t = 0;

    initial begin : monitor
        bit         prev_strobe;
        bit         ad_pending;
        logic [7:0] ad_last;
        int         ns;
        prev_strobe = 0;
        ad_pending  = 0;
        ad_last     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!i_reset_n) begin
                prev_strobe = 0;
                ad_pending  = 0;
            end else begin
                ns = int'(o_cmd_request) + int'(o_ad_request) + int'(o_rd_request);
                if (ns > 1) overlap++;
                if (ns > 0 && prev_strobe) overlap++;
                prev_strobe = (ns > 0);
                if (o_cmd_request) cmd_q.push_back(o_cmd_data);
                if (o_ad_request) begin
                    ad_q.push_back(o_ad_data);
                    ad_pending = 1;
                    ad_last    = o_ad_data;
                end else if (ad_pending && o_ad_data != ad_last) begin
                    stab_err++;
                end
                if (ad_pending && i_ad_done) ad_pending = 0;
                if (o_rd_request) rd_req_cnt++;
                if (o_data_valid) data_q.push_back(o_data);
                if (o_done) begin
                    done_cnt++;
                    done_t = cyc;
                    if (o_error) err_cnt++;
                end
                if (o_error && !o_done) err_alone++;
                if (i_cmd_done && cmd_q.size() > 0 && cmd_q[$] == 8'h30) cmd30_t = cyc;
            end
        end
    end

    // ---------------------------------------------------------------- timing controller
    bit rand_mode = 0;
    int rd_seq    = 0;

    initial begin : responder
        int kind;
        int d;
        i_cmd_done      = 1'b0;
        i_ad_done       = 1'b0;
        i_rd_data_valid = 1'b0;
        i_rd_data       = '0;
        forever begin
            @(negedge clk);
            if (i_reset_n && (o_cmd_request || o_ad_request || o_rd_request)) begin
                kind = o_cmd_request ? 0 : (o_ad_request ? 1 : 2);
                d    = rand_mode ? int'($urandom_range(10, 1)) : 1;
                repeat (d) @(posedge clk);
                #1;
                if (kind == 0) i_cmd_done = 1'b1;
                else if (kind == 1) i_ad_done = 1'b1;
                else begin
                    i_rd_data       = 16'hA000 + 16'(rd_seq);
                    rd_seq++;
                    i_rd_data_valid = 1'b1;
                end
                @(posedge clk);
                #1;
                i_cmd_done      = 1'b0;
                i_ad_done       = 1'b0;
                i_rd_data_valid = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    int cmd_base, ad_base, data_base, done_base, err_base, rd_base, seq_base;

    function automatic logic [7:0] cmd_at(input int i);
        return (i < cmd_q.size()) ? cmd_q[i] : 8'hxx;
    endfunction
    function automatic logic [7:0] ad_at(input int i);
        return (i < ad_q.size()) ? ad_q[i] : 8'hxx;
    endfunction
    function automatic logic [15:0] data_at(input int i);
        return (i < data_q.size()) ? data_q[i] : 16'hxxxx;
    endfunction

    task automatic start_xfer(input logic [11:0] col, input logic [23:0] row,
                              input logic [11:0] cnt);
        @(negedge clk);
        cmd_base  = cmd_q.size();
        ad_base   = ad_q.size();
        data_base = data_q.size();
        done_base = done_cnt;
        err_base  = err_cnt;
        rd_base   = rd_req_cnt;
        seq_base  = rd_seq;
        i_chip_ready = 1'b0;
        i_col_addr   = col;
        i_row_addr   = row;
        i_word_count = cnt;
        i_req        = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        // Scramble the descriptor: the latched copy must be what gets used.
        i_col_addr   = ~col;
        i_row_addr   = ~row;
        i_word_count = ~cnt;
    endtask

    task automatic finish_xfer(input string pfx, input int rdy_delay, input int budget);
        int t;
        t = 0;
        while (cmd_q.size() < cmd_base + 2 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check_eq({pfx, "_cmd30_seen"}, 32'(cmd_q.size() >= cmd_base + 2), 32'd1);
        if (rdy_delay >= 0) begin
            repeat (rdy_delay) @(posedge clk);
            @(negedge clk);
            i_chip_ready = 1'b1;
        end
        t = 0;
        while (done_cnt == done_base && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        i_chip_ready = 1'b0;
        check_eq({pfx, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
        check_eq({pfx, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    // exp_ad packs the five expected address bytes as {a4,a3,a2,a1,a0}.
    task automatic verify_xfer(input string pfx, input logic [39:0] exp_ad, input int nwords,
                               input int exp_err);
        check_eq({pfx, "_ncmd"}, 32'(cmd_q.size() - cmd_base), 32'd2);
        check_eq({pfx, "_cmd00"}, 32'(cmd_at(cmd_base)), 32'h00);
        check_eq({pfx, "_cmd30"}, 32'(cmd_at(cmd_base + 1)), 32'h30);
        check_eq({pfx, "_nad"}, 32'(ad_q.size() - ad_base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("%s_ad%0d", pfx, i), 32'(ad_at(ad_base + i)),
                     32'(exp_ad[8*i +: 8]));
        end
        check_eq({pfx, "_nrdreq"}, 32'(rd_req_cnt - rd_base), 32'(nwords));
        check_eq({pfx, "_ndata"}, 32'(data_q.size() - data_base), 32'(nwords));
        for (int k = 0; k < nwords; k++) begin
            check_eq($sformatf("%s_data%0d", pfx, k), 32'(data_at(data_base + k)),
                     32'(16'hA000 + 16'(seq_base + k)));
        end
        check_eq({pfx, "_error"}, 32'(err_cnt - err_base), 32'(exp_err));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : main
        int t;
        i_reset_n    = 1'b0;
        i_req        = 1'b0;
        i_col_addr   = '0;
        i_row_addr   = '0;
        i_word_count = '0;
        i_chip_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_strobes", 32'({o_cmd_request, o_ad_request, o_rd_request, o_done,
                                     o_error, o_data_valid}), 32'd0);
        check_eq("rst_data", 32'({o_data, o_cmd_data, o_ad_data}), 32'd0);
        i_reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // T1: basic 4-word read, ready 50 cycles after the 30h command.
        start_xfer(12'h123, 24'h0A0B0C, 12'd4);
        check_eq("t1_busy", 32'(o_busy), 32'd1);
        finish_xfer("t1", 50, 1000);
        verify_xfer("t1", 40'h0A_0B_0C_01_23, 4, 0);

        // T2: zero-length read completes once ready, with no read strobes.
        start_xfer(12'h010, 24'h000100, 12'd0);
        finish_xfer("t2", 10, 1000);
        verify_xfer("t2", 40'h00_01_00_00_10, 0, 0);

        // T3: ready never rises -> timeout. 30h done cycle + 20 TWB + 100 WAIT_RDY + 1.
        start_xfer(12'h7FE, 24'hFFEEDD, 12'd3);
        finish_xfer("t3", -1, 500);
        verify_xfer("t3", 40'hFF_EE_DD_07_FE, 0, 1);
        check_eq("t3_latency", 32'(done_t - cmd30_t), 32'd121);
        check_eq("t3_err_alone", 32'(err_alone), 32'd0);

        // T4: a second request during READ is ignored.
        start_xfer(12'h456, 24'h112233, 12'd6);
        fork
            finish_xfer("t4", 5, 2000);
            begin
                t = 0;
                while (data_q.size() < data_base + 2 && t < 2000) begin
                    @(posedge clk);
                    t++;
                end
                @(negedge clk);
                check_eq("t4_busy_at_inject", 32'(o_busy), 32'd1);
                i_col_addr   = 12'hFFF;
                i_row_addr   = 24'hFFFFFF;
                i_word_count = 12'd1;
                i_req        = 1'b1;
                @(negedge clk);
                i_req = 1'b0;
            end
        join
        verify_xfer("t4", 40'h11_22_33_04_56, 6, 0);
        repeat (40) @(posedge clk);
        check_eq("t4_no_restart", 32'(cmd_q.size() - cmd_base), 32'd2);

        // T5: reset during the 3rd address byte aborts with no done.
        start_xfer(12'h321, 24'h654321, 12'd2);
        t = 0;
        while (ad_q.size() < ad_base + 3 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        check_eq("t5_busy_rst", 32'(o_busy), 32'd0);
        check_eq("t5_strobes_rst", 32'({o_cmd_request, o_ad_request, o_rd_request, o_done,
                                        o_error, o_data_valid}), 32'd0);
        check_eq("t5_data_rst", 32'({o_cmd_data, o_ad_data}), 32'd0);
        repeat (10) @(posedge clk);
        check_eq("t5_no_done", 32'(done_cnt - done_base), 32'd0);
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (3) @(posedge clk);
        start_xfer(12'h0AB, 24'h010203, 12'd2);
        finish_xfer("t5b", 20, 1000);
        verify_xfer("t5b", 40'h01_02_03_00_AB, 2, 0);

        // T6: random 1-10 cycle controller delays.
        rand_mode = 1;
        start_xfer(12'hFFF, 24'h800001, 12'd10);
        finish_xfer("t6", 30, 4000);
        verify_xfer("t6", 40'h80_00_01_0F_FF, 10, 0);
        rand_mode = 0;

        check_eq("strobe_overlap", 32'(overlap), 32'd0);
        check_eq("ad_data_stable", 32'(stab_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_page_reader.md
FLASH_PAGE_READER -- requirements
Module: flash_page_reader

Interface
REQ-001 SHALL have parameter TWB_CYCLES, default 20, meaning the fixed wait after the 30h command before R/B# is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of cycles to wait for R/B# high.
REQ-003 i_master_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_req  in  1  one-cycle start strobe, sampled only in IDLE.
REQ-006 i_col_addr  in  12  column (word) address within the page.
REQ-007 i_row_addr  in  24  page/block row address.
REQ-008 i_word_count  in  12  number of 16-bit words to read.
REQ-009 o_busy  out  1  high whenever the state is not IDLE.
REQ-010 o_data  out  16  read word.
REQ-011 o_data_valid  out  1  one-cycle qualifier for o_data.
REQ-012 o_done  out  1  one-cycle pulse at completion.
REQ-013 o_error  out  1  one-cycle pulse, coincident with o_done, on a ready timeout.
REQ-014 o_cmd_request  out  1  command strobe to the timing controller.
REQ-015 o_cmd_data  out  8  command byte.
REQ-016 i_cmd_done  in  1  command completion pulse from the timing controller.
REQ-017 o_ad_request  out  1  address strobe.
REQ-018 o_ad_data  out  8  address byte.
REQ-019 i_ad_done  in  1  address completion pulse.
REQ-020 o_rd_request  out  1  read strobe.
REQ-021 i_rd_data  in  16  read data.
REQ-022 i_rd_data_valid  in  1  read data qualifier.
REQ-023 i_chip_ready  in  1  asynchronous R/B# pin; high means ready.

Function
REQ-024 States SHALL be IDLE, CMD00, ADDR, CMD30, TWB, WAIT_RDY, READ, DONE.
REQ-025 IDLE->CMD00 SHALL occur on i_req; latch col, row and count on the same edge; later input changes have no effect.
REQ-026 CMD00 SHALL drive o_cmd_data=00h and pulse o_cmd_request one cycle, then hold until i_cmd_done, then go to ADDR.
REQ-027 ADDR SHALL issue 5 address cycles in order: col[7:0], {4'b0,col[11:8]}, row[7:0], row[15:8], row[23:16].
REQ-028 Each address cycle SHALL be a one-cycle o_ad_request pulse with o_ad_data stable until i_ad_done.
REQ-029 The next address byte SHALL be issued no earlier than the cycle after i_ad_done; after the 5th done -> CMD30.
REQ-030 CMD30 SHALL send 30h with the same handshake as CMD00, then -> TWB.
REQ-031 TWB SHALL wait exactly TWB_CYCLES cycles, then -> WAIT_RDY.
REQ-032 WAIT_RDY SHALL use a 2-flop synchronized i_chip_ready; ready=1 -> READ, or -> DONE if count==0.
REQ-033 If WAIT_RDY lasts TIMEOUT_CYCLES cycles without ready -> DONE with o_error set.
REQ-034 READ SHALL pulse o_rd_request one cycle per word and wait for i_rd_data_valid before the next request.
REQ-035 Each i_rd_data_valid SHALL produce o_data=i_rd_data with o_data_valid high one cycle later (latency 1).
REQ-036 The remaining-word counter SHALL decrement on each valid; on reaching 0 -> DONE.
REQ-037 DONE SHALL pulse o_done (plus o_error if timed out) for one cycle, then -> IDLE.
REQ-038 Request strobes SHALL never be high for two consecutive cycles and never more than one simultaneously.
REQ-039 Done/valid pulses arriving in a state that is not awaiting them SHALL be ignored.
REQ-040 i_req while o_busy=1 SHALL be ignored (not queued).
REQ-041 Counters SHALL not wrap: TWB/timeout counters saturate at their terminal value; word counter 12 bits, max 4095 words.

Reset
REQ-042 While i_reset_n=0 (asynchronous), state SHALL be IDLE, all strobes/pulses 0, o_busy=0, o_data=0, o_cmd_data=0, o_ad_data=0, and all counters and synchronizer flops cleared.
REQ-043 Reset mid-transfer SHALL abort without o_done; the first request after release SHALL start a fresh sequence.

Verification
REQ-044 col=0x123, row=0x0A0B0C, count=4, ready after 50 cycles -> cmd 00h; addr 23h,01h,0Ch,0Bh,0Ah; cmd 30h; 4 words forwarded; one o_done, o_error=0.
REQ-045 count=0 -> full cmd/addr sequence, no o_rd_request, o_done after ready.
REQ-046 i_chip_ready held low, TIMEOUT_CYCLES=100 -> o_done and o_error pulse together after 100 WAIT_RDY cycles; no reads.
REQ-047 i_req pulsed during READ with different addresses -> ignored; the original transfer completes unchanged.
REQ-048 i_reset_n low during the 3rd address byte -> all outputs 0 immediately; no o_done; the next i_req restarts with 00h.
REQ-049 Timing controller delays i_ad_done/i_rd_data_valid by random 1-10 cycles -> order preserved, no strobe overlap, data count exact.
